// File: rtl/elevator_car_ctrl_if.sv
// elevator_car_ctrl_if: request and car-status signals between the car controller and the floor-request register.
// doorHold exists only when DOOR_HOLD_EN is defined.
interface elevator_car_ctrl_if;
  logic [6:1] whichFloor;
  logic       closeDoor;
  logic [6:1] currentFloor;
  logic       doorOpen;
  logic       moving;
  logic       dirUp;
`ifdef DOOR_HOLD_EN
  logic       doorHold;
  modport master (output whichFloor, doorHold, input closeDoor, currentFloor, doorOpen, moving, dirUp);
  modport slave (input whichFloor, doorHold, output closeDoor, currentFloor, doorOpen, moving, dirUp);
`else
  modport master (output whichFloor, input closeDoor, currentFloor, doorOpen, moving, dirUp);
  modport slave (input whichFloor, output closeDoor, currentFloor, doorOpen, moving, dirUp);
`endif
endinterface

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: six-floor SCAN car controller timing travel and door dwell; DOOR_HOLD_EN adds a doorHold input.
module elevator_car_ctrl #(
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input logic clk,
  input logic reset,
  elevator_car_ctrl_if.slave bus
);
  localparam int MAX_C = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAX_C);
  localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DOOR_CYCLES - 1);
  typedef enum logic [2:0] {S_DOOR, S_CLOSE, S_LOAD, S_DECIDE, S_IDLE, S_MOVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:1] floor_q, floor_d, pend_q, pend_d, below, above, step;
  logic dir_q, dir_d, hold, edge_hit;
`ifdef DOOR_HOLD_EN
  assign hold = bus.doorHold;
`else
  assign hold = 1'b0;
`endif
  // one-hot floor minus one gives the mask of every floor beneath the car
  assign below    = floor_q - 6'd1;
  assign above    = ~(floor_q | below);
  assign step     = dir_q ? {floor_q[5:1], 1'b0} : {1'b0, floor_q[6:2]};
  assign edge_hit = dir_q ? floor_q[6] : floor_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    case (state_q)
      S_DOOR: begin
        cnt_d   = (hold || cnt_q == D_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (!hold && cnt_q == D_LAST) ? S_CLOSE : S_DOOR;
      end
      S_CLOSE: state_d = S_LOAD;
      S_LOAD: begin
        pend_d  = pend_q | (bus.whichFloor & ~floor_q);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        cnt_d   = '0;
        state_d = pend_q == '0 ? S_IDLE : S_MOVE;
        dir_d   = pend_q == '0 ? dir_q : dir_q ? |(pend_q & above) : ~|(pend_q & below);
      end
      S_IDLE: begin
        cnt_d = '0;
        if (|(bus.whichFloor & floor_q)) state_d = S_DOOR;
        else if (|(bus.whichFloor & ~floor_q)) begin
          pend_d  = pend_q | (bus.whichFloor & ~floor_q);
          state_d = S_DECIDE;
        end
      end
      S_MOVE: begin
        cnt_d = cnt_q == T_LAST ? '0 : cnt_q + 1'b1;
        if (cnt_q == T_LAST) begin
          if (edge_hit) state_d = S_DOOR;
          else begin
            floor_d = step;
            if (|(pend_q & step)) begin
              pend_d  = pend_q & ~step;
              state_d = S_DOOR;
            end
          end
        end
      end
      default: state_d = S_DOOR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DOOR;
      cnt_q   <= '0;
      floor_q <= 6'b000001;
      pend_q  <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
    end
  end
  assign bus.closeDoor    = state_q == S_CLOSE || state_q == S_IDLE;
  assign bus.doorOpen     = state_q == S_DOOR;
  assign bus.moving       = state_q == S_MOVE;
  assign bus.dirUp        = dir_q;
  assign bus.currentFloor = floor_q;
endmodule
